ctrl_fsm: RTL and testbench

Multi-cycle control unit for the 8-opcode core: replaces the single-cycle combinational decoder with a registered state machine that sequences fetch, decode, execute, memory and write-back. The opcode and ALUOp widths are parametrised. Data-memory accesses use a ready handshake with a bounded wait, and a halt/start mechanism is included. It sits between the instruction register and the datapath (reg file, ALU, data memory, PC).

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/ctrl_fsm_if.sv | 33 +++
 rtl/ctrl_wait_timer.sv | 41 ++++
 rtl/ctrl_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit: state enum,
// opcode and ALU function codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_ROTR  = 3'b001;
   localparam logic [2:0] OP_NAND  = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_STORE = 3'b100;
   localparam logic [2:0] OP_MOVE  = 3'b101;
   localparam logic [2:0] OP_BNE   = 3'b110;
   localparam logic [2:0] OP_SET   = 3'b111;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_ROTR = 3'b001;
   localparam logic [2:0] ALU_NAND = 3'b010;
   localparam logic [2:0] ALU_PASS = 3'b111;

endpackage

// File: rtl/ctrl_fsm_if.sv
// Control-to-datapath bundle: opcode and memory ready come in from the
// datapath, decoded strobes go out to it.
interface ctrl_fsm_if #(
   parameter int OPW    = 3,
   parameter int ALUOPW = 3
);
   import ctrl_pkg::*;

   logic [OPW-1:0]    opcode;
   logic              mem_ready;
   logic              ir_load;
   logic              pc_en;
   logic              Branch;
   logic              ALUSrc;
   logic [ALUOPW-1:0] ALUOp;
   logic              mem_req;
   logic              MemWrite;
   logic              MemtoReg;
   logic              RegWrite;

   modport master (
      input  opcode, mem_ready,
      output ir_load, pc_en, Branch, ALUSrc, ALUOp,
             mem_req, MemWrite, MemtoReg, RegWrite
   );

   modport slave (
      output opcode, mem_ready,
      input  ir_load, pc_en, Branch, ALUSrc, ALUOp,
             mem_req, MemWrite, MemtoReg, RegWrite
   );

endinterface

// File: rtl/ctrl_wait_timer.sv
// Bounded wait counter for data-memory accesses; expired_o flags the last
// permitted cycle without mem_ready.
module ctrl_wait_timer
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Saturates at LAST so a stalled caller never sees the count wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with halt and
// memory timeout. Optional perf counters enabled by defining CTRL_PERF_CNT_EN.
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int OPW     = 3,
   parameter int ALUOPW  = 3,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt_req,
   ctrl_fsm_if.master  bus,
   output logic        halted,
   output logic        err
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0] perf_instr,
   output logic [31:0] perf_cyc
`endif
);

   localparam logic [ALUOPW-1:0] ALU_DFLT = '1;

   function automatic logic is_op(input logic [OPW-1:0] op, input logic [2:0] code);
      return op == OPW'(code);
   endfunction

   function automatic logic [ALUOPW-1:0] alu_of(input logic [OPW-1:0] op);
      if (is_op(op, OP_ADD))  return ALUOPW'(ALU_ADD);
      if (is_op(op, OP_ROTR)) return ALUOPW'(ALU_ROTR);
      if (is_op(op, OP_NAND)) return ALUOPW'(ALU_NAND);
      return ALU_DFLT;
   endfunction

   state_t            state_q;
   logic [OPW-1:0]    op_q;
   logic              ir_load_q;
   logic              pc_en_q;
   logic              branch_q;
   logic              alusrc_q;
   logic [ALUOPW-1:0] aluop_q;
   logic              mem_req_q;
   logic              memwrite_q;
   logic              memtoreg_q;
   logic              regwrite_q;
   logic              halted_q;
   logic              err_q;

   logic tmr_clear;
   logic tmr_en;
   logic tmr_expired;

   assign tmr_clear = (state_q != S_MEM);
   assign tmr_en    = (state_q == S_MEM) && !bus.mem_ready;

   ctrl_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (tmr_clear),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   // Outputs are registered alongside the state, so every branch below sets
   // the strobes of the state it is entering. halt_req is looked at on the
   // edge into FETCH so the fetch strobes can be suppressed in that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         ir_load_q  <= 1'b0;
         pc_en_q    <= 1'b0;
         branch_q   <= 1'b0;
         alusrc_q   <= 1'b0;
         aluop_q    <= ALU_DFLT;
         mem_req_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         halted_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ir_load_q  <= 1'b0;
         pc_en_q    <= 1'b0;
         branch_q   <= 1'b0;
         mem_req_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         halted_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_FETCH;
                  ir_load_q <= !halt_req;
                  pc_en_q   <= !halt_req;
               end
            end

            S_FETCH: begin
               if (ir_load_q) begin
                  state_q <= S_DECODE;
               end else if (halt_req) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else begin
                  ir_load_q <= 1'b1;
                  pc_en_q   <= 1'b1;
               end
            end

            S_DECODE: begin
               state_q  <= S_EXEC;
               op_q     <= bus.opcode;
               aluop_q  <= alu_of(bus.opcode);
               alusrc_q <= is_op(bus.opcode, OP_SET);
               branch_q <= is_op(bus.opcode, OP_BNE);
            end

            S_EXEC: begin
               if (is_op(op_q, OP_LOAD) || is_op(op_q, OP_STORE)) begin
                  state_q    <= S_MEM;
                  mem_req_q  <= 1'b1;
                  memwrite_q <= is_op(op_q, OP_STORE);
               end else if (is_op(op_q, OP_BNE)) begin
                  state_q   <= S_FETCH;
                  ir_load_q <= !halt_req;
                  pc_en_q   <= !halt_req;
                  aluop_q   <= ALU_DFLT;
                  alusrc_q  <= 1'b0;
               end else begin
                  state_q    <= S_WB;
                  regwrite_q <= 1'b1;
               end
            end

            S_MEM: begin
               if (bus.mem_ready) begin
                  if (is_op(op_q, OP_STORE)) begin
                     state_q   <= S_FETCH;
                     ir_load_q <= !halt_req;
                     pc_en_q   <= !halt_req;
                     aluop_q   <= ALU_DFLT;
                     alusrc_q  <= 1'b0;
                  end else begin
                     state_q    <= S_WB;
                     regwrite_q <= 1'b1;
                     memtoreg_q <= 1'b1;
                  end
               end else if (tmr_expired) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                  err_q    <= 1'b1;
                  aluop_q  <= ALU_DFLT;
                  alusrc_q <= 1'b0;
               end else begin
                  mem_req_q  <= 1'b1;
                  memwrite_q <= is_op(op_q, OP_STORE);
               end
            end

            S_WB: begin
               state_q   <= S_FETCH;
               ir_load_q <= !halt_req;
               pc_en_q   <= !halt_req;
               aluop_q   <= ALU_DFLT;
               alusrc_q  <= 1'b0;
            end

            S_HALT: begin
               if (start) begin
                  state_q   <= S_FETCH;
                  ir_load_q <= !halt_req;
                  pc_en_q   <= !halt_req;
                  err_q     <= 1'b0;
               end else begin
                  halted_q <= 1'b1;
               end
            end

            default: begin
               state_q  <= S_IDLE;
               aluop_q  <= ALU_DFLT;
               alusrc_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ir_load  = ir_load_q;
   assign bus.pc_en    = pc_en_q;
   assign bus.Branch   = branch_q;
   assign bus.ALUSrc   = alusrc_q;
   assign bus.ALUOp    = aluop_q;
   assign bus.mem_req  = mem_req_q;
   assign bus.MemWrite = memwrite_q;
   assign bus.MemtoReg = memtoreg_q;
   assign bus.RegWrite = regwrite_q;
   assign halted       = halted_q;
   assign err          = err_q;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] perf_instr_q;
   logic [31:0] perf_cyc_q;
   logic        retire;

   // A retiring cycle is the last cycle of an instruction.
   assign retire = (state_q == S_WB)
                || ((state_q == S_EXEC) && is_op(op_q, OP_BNE))
                || ((state_q == S_MEM) && bus.mem_ready && is_op(op_q, OP_STORE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_instr_q <= '0;
         perf_cyc_q   <= '0;
      end else begin
         if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
            perf_cyc_q <= perf_cyc_q + 32'd1;
         end
         if (retire) begin
            perf_instr_q <= perf_instr_q + 32'd1;
         end
      end
   end

   assign perf_instr = perf_instr_q;
   assign perf_cyc   = perf_cyc_q;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed self-checking bench for ctrl_fsm; scenarios chain from one
// instruction boundary (FETCH) to the next.
module tb_ctrl_fsm;

   logic clk;
   logic rst_n;
   logic start;
   logic halt_req;
   logic halted;
   logic err;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] perf_instr;
   logic [31:0] perf_cyc;
`endif

   int checks = 0;
   int errors = 0;

   ctrl_fsm_if #(.OPW(3), .ALUOPW(3)) bus ();

   ctrl_fsm #(
      .OPW     (3),
      .ALUOPW  (3),
      .TIMEOUT (15)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .halt_req (halt_req),
      .bus      (bus),
      .halted   (halted),
      .err      (err)
`ifdef CTRL_PERF_CNT_EN
      ,
      .perf_instr (perf_instr),
      .perf_cyc   (perf_cyc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ir_load, pc_en, Branch, ALUSrc, mem_req, MemWrite, MemtoReg, RegWrite, halted, err, ALUOp}
   localparam logic [12:0] IDLE_V  = 13'b0000000000_111;
   localparam logic [12:0] FETCH_V = 13'b1100000000_111;
   localparam logic [12:0] DEC_V   = 13'b0000000000_111;

   function automatic logic [12:0] obs();
      return {bus.ir_load, bus.pc_en, bus.Branch, bus.ALUSrc, bus.mem_req, bus.MemWrite,
              bus.MemtoReg, bus.RegWrite, halted, err, bus.ALUOp};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; halt_req = 1'b0;
      bus.opcode = 3'b000; bus.mem_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (obs() !== IDLE_V) begin
         errors++; $display("FAIL reset_outputs: got %b expected %b", obs(), IDLE_V);
      end
`ifdef CTRL_PERF_CNT_EN
      checks++;
      if (perf_instr !== 32'd0 || perf_cyc !== 32'd0) begin
         errors++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_instr, perf_cyc);
      end
`endif
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs() !== IDLE_V) begin
         errors++; $display("FAIL idle_hold: got %b expected %b", obs(), IDLE_V);
      end
   endtask

   task automatic test_add();
      logic [12:0] exp [5] = '{FETCH_V, DEC_V, 13'b0000000000_000, 13'b0000000100_000, FETCH_V};
      bus.opcode = 3'b000;
      start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         start = 1'b0;
         checks++;
         if (obs() !== exp[k]) begin
            errors++; $display("FAIL add_cyc%0d: got %b expected %b", k + 1, obs(), exp[k]);
         end
      end
`ifdef CTRL_PERF_CNT_EN
      checks++;
      if (perf_instr !== 32'd1 || perf_cyc !== 32'd4) begin
         errors++; $display("FAIL add_perf: got %0d/%0d expected 1/4", perf_instr, perf_cyc);
      end
`endif
   endtask

   task automatic test_alu_ops();
      logic [2:0] ops  [4] = '{3'b001, 3'b010, 3'b101, 3'b111};
      logic [2:0] aops [4] = '{3'b001, 3'b010, 3'b111, 3'b111};
      logic       srcs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [12:0] exp [4];
      for (int i = 0; i < 4; i++) begin
         exp[0] = DEC_V;
         exp[1] = {3'b000, srcs[i], 6'b000000, aops[i]};
         exp[2] = {3'b000, srcs[i], 3'b000, 1'b1, 2'b00, aops[i]};
         exp[3] = FETCH_V;
         bus.opcode = ops[i];
         for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (obs() !== exp[k]) begin
               errors++; $display("FAIL op%b_cyc%0d: got %b expected %b", ops[i], k + 2, obs(), exp[k]);
            end
         end
      end
   endtask

   task automatic test_load_wait();
      logic [12:0] exp [8] = '{DEC_V, DEC_V, 13'b0000100000_111, 13'b0000100000_111,
                               13'b0000100000_111, 13'b0000100000_111, 13'b0000001100_111, FETCH_V};
      logic        rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      bus.opcode = 3'b011;
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (obs() !== exp[k]) begin
            errors++; $display("FAIL load_cyc%0d: got %b expected %b", k + 2, obs(), exp[k]);
         end
         bus.mem_ready = rdy[k];
      end
      bus.mem_ready = 1'b0;
   endtask

   task automatic test_store_zero_wait();
      logic [12:0] exp [4] = '{DEC_V, DEC_V, 13'b0000110000_111, FETCH_V};
      logic        rdy [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      bus.opcode = 3'b100;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (obs() !== exp[k]) begin
            errors++; $display("FAIL store_cyc%0d: got %b expected %b", k + 2, obs(), exp[k]);
         end
         bus.mem_ready = rdy[k];
      end
      bus.mem_ready = 1'b0;
   endtask

   task automatic test_bne();
      logic [12:0] exp [3] = '{DEC_V, 13'b0010000000_111, FETCH_V};
      bus.opcode = 3'b110;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (obs() !== exp[k]) begin
            errors++; $display("FAIL bne_cyc%0d: got %b expected %b", k + 2, obs(), exp[k]);
         end
      end
   endtask

   task automatic test_store_timeout();
      int mem_cycles = 0;
      int rw_seen    = 0;
      logic [12:0] e;
      bus.opcode = 3'b100;
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 17; k++) begin
         tick();
         e = (k < 2) ? DEC_V : 13'b0000110000_111;
         if (bus.mem_req === 1'b1) mem_cycles++;
         if (bus.RegWrite !== 1'b0) rw_seen++;
         checks++;
         if (obs() !== e) begin
            errors++; $display("FAIL timeout_cyc%0d: got %b expected %b", k + 2, obs(), e);
         end
      end
      tick();
      if (bus.RegWrite !== 1'b0) rw_seen++;
      checks++;
      if (obs() !== 13'b0000000011_111) begin
         errors++; $display("FAIL timeout_halt: got %b expected %b", obs(), 13'b0000000011_111);
      end
      checks++;
      if (mem_cycles != 15) begin
         errors++; $display("FAIL timeout_mem_cycles: got %0d expected 15", mem_cycles);
      end
      tick();
      checks++;
      if (obs() !== 13'b0000000011_111 || rw_seen != 0) begin
         errors++; $display("FAIL timeout_sticky: got %b rw=%0d expected %b rw=0", obs(), rw_seen, 13'b0000000011_111);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (obs() !== FETCH_V) begin
         errors++; $display("FAIL timeout_restart: got %b expected %b", obs(), FETCH_V);
      end
   endtask

   task automatic test_halt_req();
      logic [12:0] exp [5] = '{DEC_V, 13'b0000000000_000, 13'b0000000100_000,
                               13'b0000000000_111, 13'b0000000010_111};
      bus.opcode = 3'b000;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (obs() !== exp[k]) begin
            errors++; $display("FAIL halt_cyc%0d: got %b expected %b", k + 2, obs(), exp[k]);
         end
         if (k == 2) halt_req = 1'b1;
      end
      halt_req = 1'b0;
      tick();
      checks++;
      if (obs() !== 13'b0000000010_111) begin
         errors++; $display("FAIL halt_hold: got %b expected %b", obs(), 13'b0000000010_111);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (obs() !== FETCH_V) begin
         errors++; $display("FAIL halt_resume: got %b expected %b", obs(), FETCH_V);
      end
   endtask

   task automatic test_reset_mid_mem();
      bus.opcode = 3'b011;
      bus.mem_ready = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (obs() !== 13'b0000100000_111) begin
         errors++; $display("FAIL rst_pre_mem: got %b expected %b", obs(), 13'b0000100000_111);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== IDLE_V) begin
         errors++; $display("FAIL rst_async: got %b expected %b", obs(), IDLE_V);
      end
`ifdef CTRL_PERF_CNT_EN
      checks++;
      if (perf_instr !== 32'd0 || perf_cyc !== 32'd0) begin
         errors++; $display("FAIL rst_perf: got %0d/%0d expected 0/0", perf_instr, perf_cyc);
      end
`endif
      bus.mem_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs() !== IDLE_V) begin
         errors++; $display("FAIL rst_stay_idle: got %b expected %b", obs(), IDLE_V);
      end
      bus.mem_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (obs() !== FETCH_V) begin
         errors++; $display("FAIL rst_restart: got %b expected %b", obs(), FETCH_V);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_ops();
      test_load_wait();
      test_store_zero_wait();
      test_bne();
      test_store_timeout();
      test_halt_req();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish within 20000 time units");
      $fatal(1, "watchdog");
   end

endmodule
